// File: rtl/md_force_accumulator.sv
// md_force_accumulator
// Sums per-pair force contributions into per-atom saturating accumulators.
// When the last contribution of a frame arrives, the per-atom totals are
// streamed out in index order.
// Optional build macro: MD_FORCE_SCALE_EN. When it is defined, each accepted
// force is arithmetic-shifted right by SCALE_SHIFT before it is added.
module md_force_accumulator #(
    parameter int N_ATOMS     = 12,
    parameter int IDX_W       = 4,
    parameter int DATA_W      = 32,
    parameter int SCALE_SHIFT = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IDX_W-1:0]         in_idx,
    input  logic signed [DATA_W-1:0] in_force,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [IDX_W-1:0]         out_idx,
    output logic signed [DATA_W-1:0] out_force,
    output logic                     busy,
    output logic                     done,
    output logic                     sat_err,
    output logic                     idx_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ACCUM,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_ATOMS - 1);
    localparam logic [IDX_W:0]   N_ATOMS_W = (IDX_W + 1)'(N_ATOMS);
    localparam logic signed [DATA_W-1:0] POS_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] NEG_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          cnt_q, cnt_d;
    logic                      sat_err_q, sat_err_d;
    logic                      idx_err_q, idx_err_d;
    logic signed [DATA_W-1:0]  acc_q [N_ATOMS];

    logic                      accept;
    logic                      idx_ok;
    logic [IDX_W-1:0]          rd_idx;
    logic signed [DATA_W-1:0]  addend;
    logic signed [DATA_W-1:0]  acc_rd;
    logic signed [DATA_W:0]    sum_wide;
    logic                      sum_ovf;
    logic signed [DATA_W-1:0]  sum_sat;

    // Clamp a one-bit-wider sum back into DATA_W; the sign of the wide sum
    // tells which rail was crossed.
    function automatic logic signed [DATA_W-1:0] saturate(input logic signed [DATA_W:0] s);
        if (s[DATA_W] != s[DATA_W-1]) begin
            return s[DATA_W] ? NEG_MIN : POS_MAX;
        end
        return s[DATA_W-1:0];
    endfunction

`ifdef MD_FORCE_SCALE_EN
    // Upstream forces carry x16 fixed point; shift back to unit scale.
    function automatic logic signed [DATA_W-1:0] scale_force(input logic signed [DATA_W-1:0] f);
        return f >>> SCALE_SHIFT;
    endfunction
    assign addend = scale_force(in_force);
`else
    logic unused_scale_shift;
    assign unused_scale_shift = ^SCALE_SHIFT;
    assign addend = in_force;
`endif

    // Out-of-range indices are steered to entry 0 for the read only; they
    // never write.
    assign idx_ok   = {1'b0, in_idx} < N_ATOMS_W;
    assign rd_idx   = idx_ok ? in_idx : '0;
    assign accept   = in_valid && (state_q == S_ACCUM);
    assign acc_rd   = acc_q[rd_idx];
    assign sum_wide = {acc_rd[DATA_W-1], acc_rd} + {addend[DATA_W-1], addend};
    assign sum_ovf  = sum_wide[DATA_W] ^ sum_wide[DATA_W-1];
    assign sum_sat  = saturate(sum_wide);

    // Next-state, counter, sticky flags and handshake outputs
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sat_err_d = sat_err_q;
        idx_err_d = idx_err_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_idx   = '0;
        out_force = '0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                done = (state_q == S_DONE);
                if (start) begin
                    state_d   = S_CLEAR;
                    cnt_d     = '0;
                    sat_err_d = 1'b0;
                    idx_err_d = 1'b0;
                end
            end
            S_CLEAR: begin
                busy = 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d = S_ACCUM;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ACCUM: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                if (in_valid) begin
                    if (!idx_ok) begin
                        idx_err_d = 1'b1;
                    end else if (sum_ovf) begin
                        sat_err_d = 1'b1;
                    end
                    if (in_last) begin
                        state_d = S_DRAIN;
                        cnt_d   = '0;
                    end
                end
            end
            S_DRAIN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_idx   = cnt_q;
                out_force = acc_q[cnt_q];
                if (out_ready) begin
                    if (cnt_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign sat_err = sat_err_q;
    assign idx_err = idx_err_q;

    // Control state register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            sat_err_q <= 1'b0;
            idx_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sat_err_q <= sat_err_d;
            idx_err_q <= idx_err_d;
        end
    end

    // Accumulator file: zeroed one entry per cycle in CLEAR, single-cycle
    // read-modify-write on each accepted in-range contribution
    always_ff @(posedge clk) begin
        if (state_q == S_CLEAR) begin
            acc_q[cnt_q] <= '0;
        end else if (accept && idx_ok) begin
            acc_q[rd_idx] <= sum_sat;
        end
    end

endmodule

// File: tb/tb_md_force_accumulator.sv
// Directed testbench for md_force_accumulator with a per-atom reference model.
module tb_md_force_accumulator;

    localparam int N  = 12;
    localparam int IW = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset, start, in_valid, in_last, out_ready;
    logic [IW-1:0] in_idx;
    logic [DW-1:0] in_force;
    logic          in_ready, out_valid, busy, done, sat_err, idx_err;
    logic [IW-1:0] out_idx;
    logic [DW-1:0] out_force;

    int checks = 0;
    int errors = 0;

    // Reference model: per-atom totals in wide arithmetic plus expected flags
    longint model [N];
    logic   exp_sat, exp_idx;

    // Words observed on the output stream, written by the compare process
    int            drain_k;
    logic [DW-1:0] captured [N];
    logic          prev_valid, prev_ready;
    logic [IW-1:0] prev_idx;
    logic [DW-1:0] prev_force;

    md_force_accumulator #(
        .N_ATOMS(N), .IDX_W(IW), .DATA_W(DW), .SCALE_SHIFT(4)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_idx(in_idx),
        .in_force(in_force), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_force(out_force), .busy(busy), .done(done),
        .sat_err(sat_err), .idx_err(idx_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] lo32(input longint v);
        return v[DW-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare process: every output word against the model, in index order,
    // and held stable while the sink stalls
    always @(negedge clk) begin
        if (reset || start) begin
            drain_k    <= 0;
            prev_valid <= 1'b0;
        end else begin
            if (out_valid) begin
                if (drain_k >= N) begin
                    chk("extra drain word", 64'(out_valid), 64'd0);
                end else begin
                    chk("drain idx", 64'(out_idx), 64'(drain_k));
                    chk("drain force", 64'(out_force), 64'(lo32(model[drain_k])));
                    if (out_ready) captured[drain_k] <= out_force;
                end
                if (prev_valid && !prev_ready) begin
                    chk("hold idx", 64'(out_idx), 64'(prev_idx));
                    chk("hold force", 64'(out_force), 64'(prev_force));
                end
                if (out_ready) drain_k <= drain_k + 1;
            end
            prev_valid <= out_valid;
            prev_ready <= out_ready;
            prev_idx   <= out_idx;
            prev_force <= out_force;
        end
    end

    task automatic start_frame();
        int n;
        for (int i = 0; i < N; i++) model[i] = 0;
        exp_sat = 1'b0;
        exp_idx = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("done cleared by start", 64'(done), 64'd0);
        chk("sat_err cleared by start", 64'(sat_err), 64'd0);
        chk("idx_err cleared by start", 64'(idx_err), 64'd0);
        chk("busy in clear", 64'(busy), 64'd1);
        n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        chk("start to in_ready cycles", 64'(n + 1), 64'(N + 1));
    endtask

    task automatic send(input int idx, input longint f, input bit last);
        longint fs, s;
        in_valid = 1'b1;
        in_idx   = idx[IW-1:0];
        in_force = lo32(f);
        in_last  = last;
        chk("in_ready during accum", 64'(in_ready), 64'd1);
        if (idx < N) begin
`ifdef MD_FORCE_SCALE_EN
            fs = f >>> 4;
`else
            fs = f;
`endif
            s = model[idx] + fs;
            if (s > 64'sd2147483647) begin
                s = 64'sd2147483647;
                exp_sat = 1'b1;
            end else if (s < -64'sd2147483648) begin
                s = -64'sd2147483648;
                exp_sat = 1'b1;
            end
            model[idx] = s;
        end else begin
            exp_idx = 1'b1;
        end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (last) begin
            chk("in_ready drops after last", 64'(in_ready), 64'd0);
            chk("out_valid one cycle after last", 64'(out_valid), 64'd1);
        end
    endtask

    task automatic drain(input bit toggle);
        int n;
        out_ready = 1'b1;
        n = 0;
        while (!done && n < 200) begin
            tick();
            if (toggle) out_ready = ~out_ready;
            n++;
        end
        out_ready = 1'b1;
        chk("drain completes", 64'(done), 64'd1);
        chk("words drained", 64'(drain_k), 64'(N));
        chk("busy after drain", 64'(busy), 64'd0);
        chk("out_valid after drain", 64'(out_valid), 64'd0);
        chk("sat_err vs model", 64'(sat_err), 64'(exp_sat));
        chk("idx_err vs model", 64'(idx_err), 64'(exp_idx));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_idx = '0; in_force = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready", 64'(in_ready), 64'd0);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset out_idx", 64'(out_idx), 64'd0);
        chk("reset out_force", 64'(out_force), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset sat_err", 64'(sat_err), 64'd0);
        chk("reset idx_err", 64'(idx_err), 64'd0);
        reset = 1'b0;
        tick();

        // Basic frame
        start_frame();
        send(0, 5, 0); send(2, -3, 0); send(0, 7, 0); send(11, 100, 1);
        drain(0);
`ifndef MD_FORCE_SCALE_EN
        chk("basic idx0", 64'(captured[0]), 64'd12);
        chk("basic idx1", 64'(captured[1]), 64'd0);
        chk("basic idx2", 64'(captured[2]), 64'hFFFF_FFFD);
        chk("basic idx11", 64'(captured[11]), 64'd100);
        chk("basic sat_err", 64'(sat_err), 64'd0);
`endif

        // Back-to-back same index
        start_frame();
        send(3, 1, 0); send(3, 1, 0); send(3, 1, 0); send(3, 1, 1);
        drain(0);
`ifndef MD_FORCE_SCALE_EN
        chk("b2b idx3", 64'(captured[3]), 64'd4);
`endif

        // Saturation at both rails
        start_frame();
        send(1, 64'sh7FFF_FFF0, 0); send(1, 64'sh100, 0);
        send(4, -64'sd2147483648, 0); send(4, -1, 1);
        drain(0);
`ifndef MD_FORCE_SCALE_EN
        chk("sat idx1", 64'(captured[1]), 64'h7FFF_FFFF);
        chk("sat idx4", 64'(captured[4]), 64'h8000_0000);
        chk("sat sat_err", 64'(sat_err), 64'd1);
`endif

        // Bad index, start ignored in ACCUM, backpressure on drain
        start_frame();
        start = 1'b1;
        send(13, 9, 0);
        start = 1'b0;
        send(2, 1, 1);
        drain(1);
        chk("badidx idx_err", 64'(idx_err), 64'd1);
`ifndef MD_FORCE_SCALE_EN
        chk("badidx idx2", 64'(captured[2]), 64'd1);
`endif

        // Reset in the middle of a drain, then a fully cleared frame
        start_frame();
        send(5, 3, 0); send(7, -2, 1);
        out_ready = 1'b1;
        repeat (5) tick();
        chk("words before reset", 64'(drain_k), 64'd5);
        reset = 1'b1;
        tick();
        chk("mid-reset out_valid", 64'(out_valid), 64'd0);
        chk("mid-reset busy", 64'(busy), 64'd0);
        chk("mid-reset done", 64'(done), 64'd0);
        reset = 1'b0;
        tick();
        start_frame();
        send(0, 0, 1);
        drain(0);
        chk("cleared idx5", 64'(captured[5]), 64'd0);
        chk("cleared idx7", 64'(captured[7]), 64'd0);

`ifdef MD_FORCE_SCALE_EN
        // Scaled contributions
        start_frame();
        send(0, 160, 0); send(0, -17, 1);
        drain(0);
        chk("scaled idx0", 64'(captured[0]), 64'd8);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/md_force_accumulator.md
Name: md_force_accumulator

Overview:
- Downstream of the MD force-compute stage.
- Accepts a stream of per-pair force contributions, each tagged with a target atom index, and sums them per atom in a local register file using saturating fixed-point arithmetic.
- On the last contribution of a frame, streams the per-atom totals out in index order to the integrator/writeback stage.
- One frame per start pulse.

Parameters:
- N_ATOMS, 12, number of atom accumulators (1..2**IDX_W).
- IDX_W, 4, width of the atom index.
- DATA_W, 32, width of force words, signed two's complement.
- SCALE_SHIFT, 4, fixed-point right-shift used only when MD_FORCE_SCALE_EN is defined.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a new frame; honoured only in IDLE or DONE
- in_valid  in  1  contribution valid
- in_ready  out  1  accumulator can accept a contribution
- in_idx  in  IDX_W  target atom index
- in_force  in  DATA_W  signed force contribution
- in_last  in  1  final contribution of the frame
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts the output word
- out_idx  out  IDX_W  atom index of the output word
- out_force  out  DATA_W  accumulated signed force
- busy  out  1  high in CLEAR, ACCUM or DRAIN
- done  out  1  frame complete; held high until the next start or reset
- sat_err  out  1  sticky: at least one accumulation saturated this frame
- idx_err  out  1  sticky: at least one in_idx >= N_ATOMS was seen this frame

Behaviour:
- Reset: state IDLE. in_ready=0, out_valid=0, out_idx=0, out_force=0, busy=0, done=0, sat_err=0, idx_err=0. Register file contents are don't-care after reset.
- Reset mid-frame aborts immediately to IDLE; no further outputs are produced.
- IDLE: start -> CLEAR. Clear sat_err, idx_err and done. Clear counter = 0.
- CLEAR: writes 0 to one accumulator per cycle, indices 0..N_ATOMS-1, taking N_ATOMS cycles. Then -> ACCUM. start is ignored.
- ACCUM:
  - in_ready=1. A handshake occurs when in_valid and in_ready are both high.
  - On handshake, acc[in_idx] <= sat(acc[in_idx] + in_force).
  - Sustained rate is 1 contribution per cycle, including back-to-back contributions to the same index. Read-modify-write completes in one cycle; no stall and no lost update.
  - Saturation clamps to +(2**(DATA_W-1)-1) or -(2**(DATA_W-1)) and sets sat_err.
  - in_idx >= N_ATOMS: contribution is dropped and idx_err is set. The handshake still completes.
  - A handshake with in_last=1 (valid or dropped) -> DRAIN on the next cycle, with in_ready=0 from that cycle.
- DRAIN:
  - out_valid=1, out_idx=k, out_force=acc[k], starting at k=0.
  - out_idx and out_force are held stable while out_ready=0.
  - On out_valid && out_ready, k increments. After the handshake at k=N_ATOMS-1 -> DONE.
  - out_valid is deasserted on the next cycle.
- DONE: busy=0, done=1. start -> CLEAR, with done cleared the same cycle as the transition. Accumulators are retained until then.
- busy is 1 exactly in CLEAR, ACCUM and DRAIN.
- start in CLEAR, ACCUM or DRAIN is ignored.
- in_valid outside ACCUM is ignored.
- Latency:
  - start to first in_ready = N_ATOMS+1 cycles.
  - in_last handshake to first out_valid = 1 cycle.

Optional Feature:
- Macro: MD_FORCE_SCALE_EN.
- Defined: each accepted in_force is arithmetic-right-shifted by SCALE_SHIFT (sign-preserving, truncating toward -inf) before the saturating add. This converts the upstream x16 fixed-point force to unit scale.
- Undefined: in_force is added unmodified. SCALE_SHIFT is unused.

Test Plan:
- Basic frame: start; contributions (idx 0,+5), (2,-3), (0,+7), (11,+100,last). Drain with out_ready=1 -> 12 words: idx0=12, idx2=-3, idx11=100, all others 0; done=1; sat_err=idx_err=0.
- Back-to-back same index: 4 consecutive cycles of (3,+1), last on the 4th -> idx3=4; in_ready never drops during ACCUM.
- Saturation: (1,0x7FFFFFF0) then (1,0x00000100,last) -> idx1=0x7FFFFFFF, sat_err=1. Also (4,0x80000000),(4,-1) -> 0x80000000.
- Backpressure and bad index: (13,+9),(2,+1,last) -> idx_err=1, idx2=1. Toggle out_ready 1/0 every cycle -> 12 words in order; outputs stable while out_ready=0.
- Reset mid-DRAIN after 5 words -> next cycle out_valid=0, busy=0, done=0. A new start then yields a fully cleared frame (all zeros if only (0,0,last) is sent).
- With MD_FORCE_SCALE_EN: (0,+160),(0,-17,last) -> idx0 = 10 + (-2) = 8.
